// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO peripheral: register map, STATUS bit positions,
// serial FSM encodings and the baud divisor helper.
package uart_mmio_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IRQEN  = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_FRM_ERR  = 5;
  localparam int ST_TX_DROP  = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; one-cycle write-to-read latency.
// Push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, baud timing, sticky-error STATUS; reads are zero-latency.
// Optional UART_IRQ_EN adds the IRQEN register at 0xC and a registered irq output.
module uart_mmio_periph
  import uart_mmio_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0400,
  parameter int               CLK_HZ    = 100_000_000,
  parameter int               BAUD      = 115200,
  parameter int               TX_DEPTH  = 8,
  parameter int               RX_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic             bus_sel,
  output logic [WIDTH-1:0] bus_rdata,
  input  logic             uart_rx,
  output logic             uart_tx
`ifdef UART_IRQ_EN
  , output logic           irq
`endif
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]       reg_idx;
  logic             aligned;
  logic             wr;
  logic             rd;
  logic             st_wr;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] irqen_word;
  logic             unused_bits;

  logic             tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_last;
  logic [7:0]       tx_head;
  tx_state_t        tx_state;
  logic [CW-1:0]    tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  logic             rx_push, rx_pop, rx_full, rx_empty, rx_last, rx_stop_hit;
  logic [7:0]       rx_head;
  rx_state_t        rx_state;
  logic [CW-1:0]    rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_prev;

  logic             rx_ovf, frm_err, tx_drop;
  logic             ovf_set, frm_set, drop_set;

  assign bus_sel     = (bus_addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign aligned     = (bus_addr[1:0] == 2'b00);
  assign reg_idx     = bus_addr[3:2];
  assign wr          = bus_sel & bus_we & aligned;
  assign rd          = bus_sel & bus_re & aligned;
  assign tx_push     = wr & (reg_idx == REG_TXDATA);
  assign st_wr       = wr & (reg_idx == REG_STATUS);
  assign rx_pop      = rd & (reg_idx == REG_RXDATA) & ~rx_empty;
  assign unused_bits = ^bus_wdata[WIDTH-1:8];

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_IDLE]  = tx_idle;
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVF]   = rx_ovf;
    status[ST_FRM_ERR]  = frm_err;
    status[ST_TX_DROP]  = tx_drop;
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_sel && aligned) begin
      case (reg_idx)
        REG_RXDATA: if (!rx_empty) bus_rdata[7:0] = rx_head;
        REG_STATUS: bus_rdata = status;
        REG_IRQEN:  bus_rdata = irqen_word;
        default:    bus_rdata = '0;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .push_dat (bus_wdata[7:0]),
    .pop      (tx_pop),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_dat (rx_shift),
    .pop      (rx_pop),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  // A queued byte follows the stop bit directly, so the FIFO is popped from STOP as well as IDLE.
  assign tx_last = (tx_cnt == DIV_LAST);
  assign tx_pop  = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_last));
  assign tx_idle = tx_empty & (tx_state == TX_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_cnt   <= '0;
      tx_shift <= tx_head;
      uart_tx  <= 1'b0;
    end else begin
      case (tx_state)
        TX_START: begin
          if (tx_last) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        default: tx_cnt <= '0;
      endcase
    end
  end

  assign rx_s        = rx_sync[1];
  assign rx_last     = (rx_cnt == DIV_LAST);
  assign rx_stop_hit = (rx_state == RX_STOP) & rx_last;
  assign rx_push     = rx_stop_hit & rx_s;
  assign frm_set     = rx_stop_hit & ~rx_s;
  assign ovf_set     = rx_push & rx_full & ~rx_pop;
  assign drop_set    = tx_push & tx_full & ~tx_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Half-bit re-check rejects glitches shorter than DIV/2.
          if (rx_cnt == HALF_LAST) begin
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        RX_DATA: begin
          if (rx_last) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        RX_STOP: begin
          if (rx_last) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf  <= 1'b0;
      frm_err <= 1'b0;
      tx_drop <= 1'b0;
    end else begin
      rx_ovf  <= (rx_ovf  & ~(st_wr & bus_wdata[ST_RX_OVF]))  | ovf_set;
      frm_err <= (frm_err & ~(st_wr & bus_wdata[ST_FRM_ERR])) | frm_set;
      tx_drop <= (tx_drop & ~(st_wr & bus_wdata[ST_TX_DROP])) | drop_set;
    end
  end

`ifdef UART_IRQ_EN
  logic [2:0] irqen;
  logic       err_any;

  assign err_any    = rx_ovf | frm_err | tx_drop;
  assign irqen_word = {{(WIDTH-3){1'b0}}, irqen};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqen <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr && (reg_idx == REG_IRQEN)) irqen <= bus_wdata[2:0];
      irq <= |(irqen & {err_any, tx_idle, ~rx_empty});
    end
  end
`else
  assign irqen_word = '0;
`endif

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Scoreboard bench for uart_mmio_periph at DIV=16 with 4-entry FIFOs.
module tb_uart_mmio_periph;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re, bus_sel;
  logic        uart_rx, uart_tx;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          tx_frames = 0;
  logic        mon_en;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];

  uart_mmio_periph #(
    .WIDTH(32), .BASE_ADDR(32'h0000_0400), .CLK_HZ(160), .BAUD(10),
    .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_sel   (bus_sel),
    .bus_rdata (bus_rdata),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
`ifdef UART_IRQ_EN
    , .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_re = 1'b0; bus_addr = 32'h0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    int i;
    i = 0;
    while (tx_frames < n && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check("tx_frame_count", 32'(tx_frames), 32'(n));
  endtask

  // Line monitor: decodes each TX frame mid-bit and compares it against the scoreboard.
  initial begin
    logic [7:0]  b;
    logic [31:0] exp;
    forever begin
      @(negedge uart_tx);
      if (mon_en && reset) begin
        repeat (8) @(posedge clk);
        #1 check("tx_start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk);
          #1 b[i] = uart_tx;
        end
        repeat (16) @(posedge clk);
        #1 check("tx_stop_bit", 32'(uart_tx), 32'd1);
        exp = (tx_q.size() != 0) ? 32'(tx_q.pop_front()) : 32'h100;
        check("tx_byte", 32'(b), exp);
        tx_frames++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp;
    reset = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    bus_we = 1'b0; bus_re = 1'b0; uart_rx = 1'b1; mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    reset = 1'b1;
    bus_read(32'h408, d);
    check("reset_status", d, 32'h2);
    bus_read(32'h404, d);
    check("reset_rxdata_empty", d, 32'h0);

    // Single byte: exact start timing, then frame decoded by the monitor.
    @(negedge clk);
    bus_addr = 32'h400; bus_wdata = 32'h55; bus_we = 1'b1;
    tx_q.push_back(8'h55);
    @(posedge clk);
    #1 check("tx_idle_after_write_edge", 32'(uart_tx), 32'd1);
    bus_we = 1'b0; bus_addr = 32'h0;
    @(posedge clk);
    #1 check("tx_start_second_edge", 32'(uart_tx), 32'd0);
    bus_read(32'h408, d);
    check("status_tx_busy", 32'(d[1]), 32'd0);
    wait_tx(1);
    repeat (12) @(posedge clk);
    bus_read(32'h408, d);
    check("status_tx_idle_again", 32'(d[1]), 32'd1);

    // Receive one byte.
    rx_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    bus_read(32'h408, d);
    check("status_rx_valid", 32'(d[2]), 32'd1);
    bus_read(32'h404, d);
    exp = 32'(rx_q.pop_front());
    check("rx_byte_a3", d, exp);
    bus_read(32'h408, d);
    check("status_rx_valid_clear", 32'(d[2]), 32'd0);

    // TX overflow: one byte in flight, four queued, fifth dropped.
    bus_write(32'h400, 32'h11); tx_q.push_back(8'h11);
    repeat (10) @(negedge clk);
    foreach (tx_q[i]) ; // keep order explicit below
    bus_write(32'h400, 32'h81); tx_q.push_back(8'h81);
    bus_write(32'h400, 32'h42); tx_q.push_back(8'h42);
    bus_write(32'h400, 32'h24); tx_q.push_back(8'h24);
    bus_write(32'h400, 32'h18); tx_q.push_back(8'h18);
    bus_read(32'h408, d);
    check("status_tx_full", 32'(d[0]), 32'd1);
    check("status_no_drop_yet", 32'(d[6]), 32'd0);
    bus_write(32'h400, 32'hEE);
    bus_read(32'h408, d);
    check("status_tx_drop", 32'(d[6]), 32'd1);
    bus_write(32'h408, 32'h40);
    bus_read(32'h408, d);
    check("status_tx_drop_w1c", 32'(d[6]), 32'd0);
    wait_tx(6);

    // RX overflow: five frames unread, first four kept in order.
    for (int i = 0; i < 5; i++) begin
      d = 32'(8'h30 + 8'(i * 17));
      if (i < 4) rx_q.push_back(d[7:0]);
      send_frame(d[7:0], 1'b1);
    end
    bus_read(32'h408, d);
    check("status_rx_full", 32'(d[3]), 32'd1);
    check("status_rx_ovf", 32'(d[4]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h404, d);
      exp = 32'(rx_q.pop_front());
      check("rx_ovf_order", d, exp);
    end
    bus_read(32'h408, d);
    check("status_rx_drained", 32'(d[2]), 32'd0);
    bus_write(32'h408, 32'h10);
    bus_read(32'h408, d);
    check("status_rx_ovf_w1c", 32'(d[4]), 32'd0);

    // Short glitch must not start a frame; receiver still works afterwards.
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(32'h408, d);
    check("glitch_no_byte", 32'(d[2]), 32'd0);
    rx_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    bus_read(32'h404, d);
    exp = 32'(rx_q.pop_front());
    check("rx_after_glitch", d, exp);

    // Framing error, then empty read leaves the FIFO untouched.
    send_frame(8'h5A, 1'b0);
    bus_read(32'h408, d);
    check("frm_no_push", 32'(d[2]), 32'd0);
    check("frm_err_set", 32'(d[5]), 32'd1);
    bus_read(32'h404, d);
    check("rx_empty_read_zero", d, 32'h0);
    rx_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    bus_read(32'h404, d);
    exp = 32'(rx_q.pop_front());
    check("rx_after_empty_read", d, exp);
    bus_read(32'h404, d);
    check("rx_single_entry", d, 32'h0);

    // Decode edge cases.
    bus_write(32'h401, 32'h99);
    repeat (4) @(negedge clk);
    bus_read(32'h408, d);
    check("misaligned_write_ignored", 32'(d[1]), 32'd1);
    bus_read(32'h40A, d);
    check("misaligned_read_zero", d, 32'h0);
    @(negedge clk);
    bus_addr = 32'h410;
    #1 check("sel_above_window", 32'(bus_sel), 32'd0);
    bus_addr = 32'h3FC;
    #1 check("sel_below_window", 32'(bus_sel), 32'd0);
    bus_addr = 32'h40C;
    #1 check("sel_in_window", 32'(bus_sel), 32'd1);
    bus_addr = 32'h0;
    bus_write(32'h408, 32'h70);
    bus_read(32'h408, d);
    check("status_all_clear", d, 32'h2);

`ifdef UART_IRQ_EN
    bus_write(32'h40C, 32'h1);
    bus_read(32'h40C, d);
    check("irqen_readback", d, 32'h1);
    check("irq_quiet", 32'(irq), 32'd0);
    rx_q.push_back(8'hC5);
    send_frame(8'hC5, 1'b1);
    check("irq_rx_valid", 32'(irq), 32'd1);
    bus_read(32'h404, d);
    exp = 32'(rx_q.pop_front());
    check("irq_rx_byte", d, exp);
    repeat (2) @(posedge clk);
    #1 check("irq_cleared", 32'(irq), 32'd0);
    bus_write(32'h40C, 32'h0);
`else
    bus_write(32'h40C, 32'h7);
    bus_read(32'h40C, d);
    check("irqen_absent_zero", d, 32'h0);
`endif

    // Reset in the middle of a frame forces the line high at once.
    mon_en = 1'b0;
    bus_write(32'h400, 32'h00);
    repeat (40) @(posedge clk);
    #1 check("tx_mid_frame_low", 32'(uart_tx), 32'd0);
    #2 reset = 1'b0;
    #1 check("tx_async_reset", 32'(uart_tx), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus_read(32'h408, d);
    check("status_after_reset", d, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
